// File: rtl/continuous_assignment_example.sv
`default_nettype none
// ============================================================================
// Module   : continuous_assignment_example
// Purpose  : Continuous-assignment OR gate plus clocked gate bank, rising-edge
//            detector and saturating high-cycle counter on the same inputs.
// Revision : 1.0 - initial release
// ============================================================================
module continuous_assignment_example #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic [2:0]       sel,
    input  logic             clr,
    output logic             c,
    output logic             y,
    output logic             y_q,
    output logic [5:0]       gates_q,
    output logic             c_rise,
    output logic [CNT_W-1:0] high_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [5:0]       w_gates;
    logic             w_y;
    logic             r_y_q;
    logic [5:0]       r_gates_q;
    logic             r_c_q;
    logic             r_c_rise;
    logic [CNT_W-1:0] r_high_count;

    // Plain operators keep 4-state X propagation on the combinational path.
    assign c       = a | b;
    assign w_gates = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a & b, a | b};

    always_comb begin
        w_y = 1'b0;
        case (sel)
            3'd0: w_y = w_gates[0];
            3'd1: w_y = w_gates[1];
            3'd2: w_y = w_gates[2];
            3'd3: w_y = w_gates[3];
            3'd4: w_y = w_gates[4];
            3'd5: w_y = w_gates[5];
            3'd6: w_y = a;
            3'd7: w_y = b;
        endcase
    end

    assign y = w_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q        <= 1'b0;
            r_gates_q    <= 6'b000000;
            r_c_q        <= 1'b0;
            r_c_rise     <= 1'b0;
            r_high_count <= '0;
        end else begin
            r_y_q     <= w_y;
            r_gates_q <= w_gates;
            r_c_q     <= c;
            r_c_rise  <= c & ~r_c_q;
            // Clear beats increment; the count sticks at all-ones.
            if (clr) begin
                r_high_count <= '0;
            end else if (c && (r_high_count != C_CNT_MAX)) begin
                r_high_count <= r_high_count + 1'b1;
            end
        end
    end

    assign y_q        = r_y_q;
    assign gates_q    = r_gates_q;
    assign c_rise     = r_c_rise;
    assign high_count = r_high_count;

endmodule
`default_nettype wire

// File: tb/tb_continuous_assignment_example.sv
`default_nettype none
// Directed testbench for continuous_assignment_example (default 8-bit counter
// instance plus a 4-bit instance for saturation), immediate-assertion checks.
`timescale 1ns/1ps
module tb_continuous_assignment_example;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n;
    logic       a;
    logic       b;
    logic [2:0] sel;
    logic       clr;

    logic       c, y, y_q, c_rise;
    logic [5:0] gates_q;
    logic [7:0] high_count;

    logic       s_c, s_y, s_y_q, s_c_rise;
    logic [5:0] s_gates_q;
    logic [3:0] s_high_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = clk_en ? ~clk : 1'b0;

    continuous_assignment_example #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .clr(clr),
        .c(c), .y(y), .y_q(y_q), .gates_q(gates_q), .c_rise(c_rise),
        .high_count(high_count)
    );

    continuous_assignment_example #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .clr(clr),
        .c(s_c), .y(s_y), .y_q(s_y_q), .gates_q(s_gates_q), .c_rise(s_c_rise),
        .high_count(s_high_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_y_q"},     {31'd0, y_q},       32'd0);
        chk({tag, "_gates_q"}, {26'd0, gates_q},   32'd0);
        chk({tag, "_c_rise"},  {31'd0, c_rise},    32'd0);
        chk({tag, "_count"},   {24'd0, high_count}, 32'd0);
    endtask

    logic [1:0] tt_in  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic       tt_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       y_exp  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        sel   = 3'd0;

        // Undriven operands: c must follow the 4-state OR of the bench inputs.
        #1;
        chk("c_undriven", {31'd0, c}, {31'd0, a | b});

        // Truth table with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            a = tt_in[i][1];
            b = tt_in[i][0];
            #1000;
            chk($sformatf("tt_c_%0d", i), {31'd0, c}, {31'd0, tt_exp[i]});
            chk($sformatf("tt_y_or_%0d", i), {31'd0, y}, {31'd0, tt_exp[i]});
        end

        // Reset held for two edges with c = 1.
        clk_en = 1'b1;
        a = 1'b1;
        b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_regs_zero($sformatf("rst%0d", i));
            chk($sformatf("rst%0d_c", i), {31'd0, c}, 32'd1);
        end

        rst_n = 1'b1;
        tick();
        chk("rel_c_rise", {31'd0, c_rise}, 32'd1);
        chk("rel_count",  {24'd0, high_count}, 32'd1);
        tick();
        chk("rel2_c_rise", {31'd0, c_rise}, 32'd0);
        chk("rel2_count",  {24'd0, high_count}, 32'd2);

        // sel sweep with a=1, b=0.
        a = 1'b1;
        b = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk($sformatf("y_sel%0d", s), {31'd0, y}, {31'd0, y_exp[s]});
            tick();
            chk($sformatf("y_q_sel%0d", s), {31'd0, y_q}, {31'd0, y_exp[s]});
        end
        chk("gates_10", {26'd0, gates_q}, {26'd0, 6'b001101});
        chk("count_10", {24'd0, high_count}, 32'd10);

        // Remaining gate-bank patterns and a second rising edge.
        a = 1'b1; b = 1'b1;
        tick();
        chk("gates_11", {26'd0, gates_q}, {26'd0, 6'b100011});
        a = 1'b0; b = 1'b0;
        tick();
        chk("gates_00", {26'd0, gates_q}, {26'd0, 6'b111000});
        chk("count_hold", {24'd0, high_count}, 32'd11);
        a = 1'b0; b = 1'b1;
        tick();
        chk("gates_01", {26'd0, gates_q}, {26'd0, 6'b001101});
        chk("rise2", {31'd0, c_rise}, 32'd1);
        chk("count_12", {24'd0, high_count}, 32'd12);

        // Clear colliding with an increment.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; a = 1'b0; b = 1'b0;
        tick();
        a = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_clr_count", {24'd0, high_count}, 32'd5);
        clr = 1'b1;
        tick();
        chk("clr_count", {24'd0, high_count}, 32'd0);
        chk("clr_gates", {26'd0, gates_q}, {26'd0, 6'b001101});
        clr = 1'b0;
        tick();
        chk("post_clr_count", {24'd0, high_count}, 32'd1);

        // Saturation on the 4-bit instance.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; a = 1'b1; b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_reach", {28'd0, s_high_count}, 32'd15);
        end
        chk("sat_hold", {28'd0, s_high_count}, 32'd15);
        chk("wide_20",  {24'd0, high_count}, 32'd20);

        // Mid-run reset at count 7.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_count7", {24'd0, high_count}, 32'd7);
        rst_n = 1'b0;
        tick();
        chk_regs_zero("mid_rst");
        chk("mid_rst_c", {31'd0, c}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
